// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file types and widths, used by the register file
// and by its read-side client reg_read_stage.
package rf_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned REG_IDX_W = $clog2(NREGS);

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]      word_t;

  // Operand bundle held in the read-stage output register.
  typedef struct packed {
    word_t    rs1_data;
    word_t    rs2_data;
    reg_idx_t rd;
    logic     rd_wen;
  } ex_payload_t;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write scoreboard, one bit per architectural register.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   set_en, set_idx     accepted producer claims its destination register
//   wb_valid, wb_rd     writeback event; clears the bit and resolves WAW
//   rs1/rs2/rd, use_*   the decode-side query
//   rd_wen              the queried instruction writes rd
//   wb_hit_rs1/rs2      same-cycle writeback forwarding is available
//   pending             scoreboard vector (bit 0 always 0)
//   hazard_c            combinational: RAW on either used operand, or WAW
module reg_scoreboard
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  reg_idx_t         set_idx,
  input  logic             wb_valid,
  input  reg_idx_t         wb_rd,
  input  reg_idx_t         rs1,
  input  reg_idx_t         rs2,
  input  reg_idx_t         rd,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic             rd_wen,
  input  logic             wb_hit_rs1,
  input  logic             wb_hit_rs2,
  output logic [NREGS-1:0] pending,
  output logic             hazard_c
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic             raw_rs1;
  logic             raw_rs2;
  logic             waw;

  // Next state: clear first so a same-cycle set wins; x0 never pends.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid && (wb_rd != '0)) pend_d[wb_rd] = 1'b0;
    if (set_en && (set_idx != '0)) pend_d[set_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // The writeback retiring the old producer of rd lifts WAW in both modes.
  always_comb begin
    raw_rs1  = use_rs1 && pend_q[rs1] && !wb_hit_rs1;
    raw_rs2  = use_rs2 && pend_q[rs2] && !wb_hit_rs2;
    waw      = rd_wen && pend_q[rd] && !(wb_valid && (wb_rd == rd));
    hazard_c = raw_rs1 || raw_rs2 || waw;
  end

  assign pending = pend_q;

endmodule

// File: rtl/reg_read_stage.sv
// reg_read_stage: operand-read stage between decode and execute.
// Drives the register-file read addresses, blocks RAW/WAW hazards through
// reg_scoreboard, forwards same-cycle writeback data, and holds operands in a
// one-entry valid/ready output register.
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   id_*                                decode handshake and register fields
//   rf_addr_rs1/rs2, rf_data_rs1/rs2    combinational register-file read port
//   wb_valid, wb_rd, wb_data            writeback event (register-file write)
//   ex_valid, ex_ready, ex_*            registered operands to execute
//   pending                             scoreboard vector for debug
// Build option: define WB_BYPASS_EN to forward writeback data in the same
// cycle; without it a consumer waits one extra cycle and reads the file.
module reg_read_stage
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  output logic             id_ready,
  input  reg_idx_t         id_rs1,
  input  reg_idx_t         id_rs2,
  input  reg_idx_t         id_rd,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_rd_wen,
  output reg_idx_t         rf_addr_rs1,
  output reg_idx_t         rf_addr_rs2,
  input  word_t            rf_data_rs1,
  input  word_t            rf_data_rs2,
  input  logic             wb_valid,
  input  reg_idx_t         wb_rd,
  input  word_t            wb_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output word_t            ex_rs1_data,
  output word_t            ex_rs2_data,
  output reg_idx_t         ex_rd,
  output logic             ex_rd_wen,
  output logic [NREGS-1:0] pending
);

  logic        wb_hit_rs1;
  logic        wb_hit_rs2;
  logic        hazard;
  logic        slot_free;
  logic        accept;
  logic        ex_valid_q;
  ex_payload_t ex_q;
  ex_payload_t ex_d;

  assign rf_addr_rs1 = id_rs1;
  assign rf_addr_rs2 = id_rs2;

  // Writeback forwarding hits; x0 is never forwarded.
`ifdef WB_BYPASS_EN
  assign wb_hit_rs1 = wb_valid && (wb_rd == id_rs1) && (id_rs1 != '0);
  assign wb_hit_rs2 = wb_valid && (wb_rd == id_rs2) && (id_rs2 != '0);
`else
  logic unused_wb_data;
  assign wb_hit_rs1     = 1'b0;
  assign wb_hit_rs2     = 1'b0;
  assign unused_wb_data = ^wb_data;
`endif

  reg_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_en     (accept && id_rd_wen),
    .set_idx    (id_rd),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .rs1        (id_rs1),
    .rs2        (id_rs2),
    .rd         (id_rd),
    .use_rs1    (id_use_rs1),
    .use_rs2    (id_use_rs2),
    .rd_wen     (id_rd_wen),
    .wb_hit_rs1 (wb_hit_rs1),
    .wb_hit_rs2 (wb_hit_rs2),
    .pending    (pending),
    .hazard_c   (hazard)
  );

  assign slot_free = !ex_valid_q || ex_ready;
  assign id_ready  = slot_free && !hazard;
  assign accept    = id_valid && id_ready;

  // Operand select: x0 reads zero, then forwarded writeback, then the file.
  always_comb begin
    ex_d.rs1_data = rf_data_rs1;
    ex_d.rs2_data = rf_data_rs2;
    ex_d.rd       = id_rd;
    ex_d.rd_wen   = id_rd_wen;
    if (id_rs1 == '0)    ex_d.rs1_data = '0;
    else if (wb_hit_rs1) ex_d.rs1_data = wb_data;
    if (id_rs2 == '0)    ex_d.rs2_data = '0;
    else if (wb_hit_rs2) ex_d.rs2_data = wb_data;
  end

  // Output register: load on accept, drop on drain, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_q       <= ex_d;
    end else if (ex_ready) begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_rs1_data = ex_q.rs1_data;
  assign ex_rs2_data = ex_q.rs2_data;
  assign ex_rd       = ex_q.rd;
  assign ex_rd_wen   = ex_q.rd_wen;

endmodule

// File: tb/tb_reg_read_stage.sv
// tb_reg_read_stage: self-checking bench for reg_read_stage with a behavioural
// register file and a queue of expected operand bundles.
module tb_reg_read_stage;
  import rf_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic             id_ready;
  reg_idx_t         id_rs1, id_rs2, id_rd;
  logic             id_use_rs1, id_use_rs2, id_rd_wen;
  reg_idx_t         rf_addr_rs1, rf_addr_rs2;
  word_t            rf_data_rs1, rf_data_rs2;
  logic             wb_valid;
  reg_idx_t         wb_rd;
  word_t            wb_data;
  logic             ex_valid;
  logic             ex_ready;
  word_t            ex_rs1_data, ex_rs2_data;
  reg_idx_t         ex_rd;
  logic             ex_rd_wen;
  logic [NREGS-1:0] pending;

  word_t       rf_mem [NREGS];
  ex_payload_t exp_q [$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  reg_read_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rd       (id_rd),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd_wen   (id_rd_wen),
    .rf_addr_rs1 (rf_addr_rs1),
    .rf_addr_rs2 (rf_addr_rs2),
    .rf_data_rs1 (rf_data_rs1),
    .rf_data_rs2 (rf_data_rs2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_rs1_data (ex_rs1_data),
    .ex_rs2_data (ex_rs2_data),
    .ex_rd       (ex_rd),
    .ex_rd_wen   (ex_rd_wen),
    .pending     (pending)
  );

  // Behavioural register file sharing the writeback port.
  assign rf_data_rs1 = rf_mem[rf_addr_rs1];
  assign rf_data_rs2 = rf_mem[rf_addr_rs2];
  always @(posedge clk) begin
    if (wb_valid && (wb_rd != '0)) rf_mem[wb_rd] <= wb_data;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Completed handshakes pop the oldest expected bundle.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ex_unexpected", 64'(1), 64'(0));
      end else begin
        ex_payload_t e;
        e = exp_q.pop_front();
        check("ex_rs1_data", 64'(ex_rs1_data), 64'(e.rs1_data));
        check("ex_rs2_data", 64'(ex_rs2_data), 64'(e.rs2_data));
        check("ex_rd",       64'(ex_rd),       64'(e.rd));
        check("ex_rd_wen",   64'(ex_rd_wen),   64'(e.rd_wen));
      end
    end
  end

  // Drive one cycle of stimulus, check id_ready, record the expected bundle.
  task automatic issue(input bit v, input int rs1, input int rs2, input int rd,
                       input bit u1, input bit u2, input bit wen,
                       input bit wv, input int wrd, input word_t wd,
                       input bit exr, input bit exp_rdy,
                       input word_t e1, input word_t e2);
    ex_payload_t e;
    id_valid   = v;
    id_rs1     = REG_IDX_W'(rs1);
    id_rs2     = REG_IDX_W'(rs2);
    id_rd      = REG_IDX_W'(rd);
    id_use_rs1 = u1;
    id_use_rs2 = u2;
    id_rd_wen  = wen;
    wb_valid   = wv;
    wb_rd      = REG_IDX_W'(wrd);
    wb_data    = wd;
    ex_ready   = exr;
    #1;
    if (v) begin
      check("id_ready", 64'(id_ready), 64'(exp_rdy));
      check("rf_addr_rs1", 64'(rf_addr_rs1), 64'(rs1));
      if (exp_rdy) begin
        e.rs1_data = e1;
        e.rs2_data = e2;
        e.rd       = REG_IDX_W'(rd);
        e.rd_wen   = wen;
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wb_only(input int wrd, input word_t wd);
    issue(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, wrd, wd, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic idle();
    issue(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, '0, 1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < int'(NREGS); i++) rf_mem[i] = '0;
    rf_mem[5] = 32'h11;
    rf_mem[6] = 32'h22;
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd_wen = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0; ex_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_ex_valid", 64'(ex_valid), 64'(0));
    check("rst_ex_rs1", 64'(ex_rs1_data), 64'(0));
    check("rst_ex_rs2", 64'(ex_rs2_data), 64'(0));
    check("rst_ex_rd", 64'({ex_rd, ex_rd_wen}), 64'(0));
    check("rst_id_ready", 64'(id_ready), 64'(1));

    // No hazard
    issue(1, 5, 6, 7, 1, 1, 1, 0, 0, '0, 1, 1, 32'h11, 32'h22);
    check("nohz_ex_valid", 64'(ex_valid), 64'(1));
    check("nohz_pending", 64'(pending), 64'(32'h80));

    // RAW on x7 resolved by the writeback of x7
`ifdef WB_BYPASS_EN
    issue(1, 7, 5, 8, 1, 1, 1, 1, 7, 32'hDEAD, 1, 1, 32'hDEAD, 32'h11);
`else
    issue(1, 7, 5, 8, 1, 1, 1, 1, 7, 32'hDEAD, 1, 0, '0, '0);
    check("raw_nobyp_pending", 64'(pending), 64'(0));
    issue(1, 7, 5, 8, 1, 1, 1, 0, 0, '0, 1, 1, 32'hDEAD, 32'h11);
`endif
    check("raw_pending", 64'(pending), 64'(32'h100));
    wb_only(8, 32'h88);
    check("clr8_pending", 64'(pending), 64'(0));

    // RAW stall without writeback
    issue(1, 0, 0, 9, 0, 0, 1, 0, 0, '0, 1, 1, '0, '0);
    for (int i = 0; i < 4; i++) begin
      issue(1, 9, 0, 10, 1, 0, 1, 0, 0, '0, 1, 0, '0, '0);
    end
    check("stall_ex_valid", 64'(ex_valid), 64'(0));
    check("stall_pending", 64'(pending), 64'(32'h200));
    wb_only(9, 32'h99);
    check("clr9_pending", 64'(pending), 64'(0));

    // WAW on x3, released by the writeback of x3 in the same cycle
    issue(1, 0, 0, 3, 0, 0, 1, 0, 0, '0, 1, 1, '0, '0);
    issue(1, 0, 0, 3, 0, 0, 1, 0, 0, '0, 1, 0, '0, '0);
    issue(1, 0, 0, 3, 0, 0, 1, 1, 3, 32'h33, 1, 1, '0, '0);
    check("waw_pending", 64'(pending), 64'(32'h8));
    wb_only(3, 32'h34);
    check("clr3_pending", 64'(pending), 64'(0));

    // x0 reads zero and never pends, even while x0 is written
    issue(1, 0, 5, 0, 1, 1, 1, 1, 0, 32'h55, 1, 1, '0, 32'h11);
    check("x0_pending", 64'(pending), 64'(0));

    // Backpressure holds the entry and blocks decode
    issue(1, 5, 6, 0, 1, 1, 0, 0, 0, '0, 1, 1, 32'h11, 32'h22);
    issue(1, 6, 5, 12, 1, 1, 1, 0, 0, '0, 0, 0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      issue(1, 6, 5, 12, 1, 1, 1, 0, 0, '0, 0, 0, '0, '0);
    end
    check("bp_ex_valid", 64'(ex_valid), 64'(1));
    check("bp_ex_rs1", 64'(ex_rs1_data), 64'(32'h11));
    check("bp_ex_rs2", 64'(ex_rs2_data), 64'(32'h22));
    check("bp_pending", 64'(pending), 64'(0));

    // Set a pending bit, then reset mid-operation with an entry held
    ex_ready = 1'b0;
    issue(1, 0, 0, 12, 0, 0, 1, 0, 0, '0, 0, 0, '0, '0);
    ex_ready = 1'b1;
    issue(1, 0, 0, 12, 0, 0, 1, 0, 0, '0, 1, 1, '0, '0);
    check("pre_rst_pending", 64'(pending), 64'(32'h1000));
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0, '0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    check("rst2_ex_valid", 64'(ex_valid), 64'(0));
    check("rst2_pending", 64'(pending), 64'(0));

    // Back-to-back issue at full throughput
    issue(1, 5, 6, 13, 1, 1, 0, 0, 0, '0, 1, 1, 32'h11, 32'h22);
    issue(1, 6, 7, 14, 1, 1, 0, 0, 0, '0, 1, 1, 32'h22, 32'hDEAD);
    issue(1, 9, 3, 15, 1, 1, 0, 0, 0, '0, 1, 1, 32'h99, 32'h34);
    idle();
    idle();
    check("drained", 64'(exp_q.size()), 64'(0));
    check("end_ex_valid", 64'(ex_valid), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_read_stage.md
# reg_read_stage

Operand-read stage that sits between decode and execute and is the read-side client of the register file. It drives the file's two combinational read addresses, blocks RAW/WAW hazards with a pending-write scoreboard, and bypasses same-cycle writeback data. It presents operands to execute through a one-entry valid/ready pipeline register. The writeback port it monitors is the same event that drives the register file's write port.

## Interface
- XLEN, 32: data width.
- NREGS, 32: architectural registers; index width is $clog2(NREGS) (5 at default).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_use_rs1, id_use_rs2  in  1 each  the instruction reads that operand.
- id_rd_wen  in  1  the instruction writes rd.
- rf_addr_rs1, rf_addr_rs2  out  5 each  register-file read addresses; equal to id_rs1/id_rs2 combinationally.
- rf_data_rs1, rf_data_rs2  in  XLEN each  combinational register-file read data.
- wb_valid, wb_rd, wb_data  in  1/5/XLEN  writeback event, identical to the register-file write port.
- ex_valid  out  1  operands are valid.
- ex_ready  in  1  execute accepts them.
- ex_rs1_data, ex_rs2_data  out  XLEN each  operand values.
- ex_rd, ex_rd_wen  out  5/1  destination, passed through.
- pending  out  NREGS  scoreboard vector, for debug.

## Operation
- Scoreboard: one bit per register; bit 0 is hard-wired to 0.
- Set: on an accepted instruction with id_rd_wen=1 and id_rd≠0, bit id_rd is set.
- Clear: wb_valid=1 and wb_rd≠0 clears bit wb_rd.
- Same register set and cleared in one cycle: set wins (the new producer owns the register).
- wb_hit_rsN = wb_valid & wb_rd==id_rsN & id_rsN≠0.
- RAW hazard on operand N: id_use_rsN & pending[id_rsN] & ~wb_hit_rsN.
- WAW hazard: id_rd_wen & pending[id_rd] & ~(wb_valid & wb_rd==id_rd).
- Output register: slot_free = ~ex_valid | ex_ready.
- id_ready = slot_free & ~RAW & ~WAW.
- Accept = id_valid & id_ready.
- Operand select, per operand: index 0 gives 0; else wb_hit gives wb_data; else rf_data.
- Accept loads ex_* with the selected operands and rd fields, and sets ex_valid=1.
- ex_ready=1 with no accept clears ex_valid. Accept and drain in the same cycle replace the entry.
- ex_* hold stable while ex_valid=1 and ex_ready=0.
- Unused operands (id_use_rsN=0) never stall. Their data is still loaded.

## Timing
- Reset: pending=0, ex_valid=0, ex_rs1_data=ex_rs2_data=0, ex_rd=0, ex_rd_wen=0. id_ready follows from this reset state.
- Reset mid-operation discards the output entry and all pending bits. A wb after reset clears an already-zero bit, which is harmless.
- Latency: accept in cycle N gives ex_valid=1 in cycle N+1.
- Throughput: one instruction per cycle with no hazards.
- The register file writes on the same edge that clears the pending bit, so rf_data is current from the next cycle onward.
- id_ready has a combinational path from ex_ready, wb_*, and id_*. ex_* are registered.

## Configuration
- WB_BYPASS_EN defined: same-cycle writeback forwarding as described above.
- WB_BYPASS_EN undefined:
  - wb_hit is forced to 0 for RAW checking and operand selection.
  - A consumer of a pending register stalls through the writeback cycle and issues the next cycle with rf_data.
  - The RAW penalty grows by one cycle.
  - The WAW rule is unchanged in both modes.

## Structure
- Shared package rf_pkg: XLEN, NREGS, REG_IDX_W, and the reg_idx_t and word_t typedefs. The register file uses the same package.
- One sub-module, reg_scoreboard: the pending vector, set/clear/priority logic, and the hazard query for rs1, rs2 and rd.
- Operand muxing and the output register stay in reg_read_stage.

## Test plan
- No hazard:
  - Stimulus: reset; rf holds x5=0x11, x6=0x22; issue rs1=5, rs2=6, rd=7 with ex_ready=1.
  - Response: next cycle ex_rs1_data=0x11, ex_rs2_data=0x22, ex_rd=7, and pending[7]=1.
- RAW with bypass:
  - Stimulus: pending[7]=1; issue a reader of x7 in the same cycle as wb_valid, wb_rd=7, wb_data=0xDEAD.
  - Response: accepted; ex_rs1_data=0xDEAD; pending[7]=0.
  - Bypass compiled out: id_ready=0 that cycle; accepted the next cycle with rf data 0xDEAD.
- RAW stall: pending[9]=1 with no wb → id_ready=0 indefinitely; ex_valid falls after drain; no pending change.
- WAW: pending[3]=1; issue rd=3 with no wb → stall; wb to x3 arrives → accepted the same cycle and pending[3] stays 1.
- x0: issue rs1=0, rd=0 while wb writes x0=0x55 → ex_rs1_data=0 and pending[0] stays 0.
- Backpressure and reset:
  - Stimulus: ex_ready=0 with ex_valid=1.
  - Response: id_ready=0 and ex_* unchanged for 3 cycles.
  - Stimulus: rst_n=0 for one cycle.
  - Response: ex_valid=0 and pending=0 on the next cycle.
